mem_port_arbiter: RTL

//  Shares one single-ported unified memory between instruction fetch (I-side) and load/store (D-side).

---
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Round-robin grant, one transaction in flight, watchdog timeout, protocol error flagging.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_done,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_done,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  err,
    output logic                  err_sticky
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_ACC, S_WAIT_RESP} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_last_grant, w_last_grant_nxt;
    logic                r_side, w_side_nxt;
    logic                r_we, w_we_nxt;
    logic [BE_W-1:0]     r_be, w_be_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic                r_mem_req, w_mem_req_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_i_done, w_i_done_nxt;
    logic                r_d_done, w_d_done_nxt;
    logic [DATA_W-1:0]   r_i_rdata, w_i_rdata_nxt;
    logic [DATA_W-1:0]   r_d_rdata, w_d_rdata_nxt;
    logic                r_err, w_err_nxt;
    logic                r_err_sticky;
    logic                r_armed, w_armed_nxt;

    logic                w_grant, w_grant_d, w_timeout, w_rvalid_ok, w_proto;
    logic                w_done, w_fail;
    logic [DATA_W-1:0]   w_rdata_fin;

    assign w_grant     = i_req | d_req;
    assign w_grant_d   = d_req & (~i_req | (r_last_grant == SIDE_I));
    assign w_timeout   = (r_cnt == CNT_LAST);
    assign w_rvalid_ok = (r_state == S_WAIT_RESP) || ((r_state == S_WAIT_ACC) && !r_we);
    // Stray beats are only flagged once a transaction has been issued since reset,
    // so a response belonging to an abandoned pre-reset access is silently dropped.
    assign w_proto     = r_armed & ((mem_rvalid & ~w_rvalid_ok) | (mem_ready & ~r_mem_req));

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_grant) w_state_nxt = S_WAIT_ACC;
            S_WAIT_ACC: begin
                if (mem_ready)      w_state_nxt = (r_we || mem_rvalid) ? S_IDLE : S_WAIT_RESP;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_WAIT_RESP: if (mem_rvalid || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        w_last_grant_nxt = r_last_grant;
        w_side_nxt       = r_side;
        w_we_nxt         = r_we;
        w_be_nxt         = r_be;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_mem_req_nxt    = r_mem_req;
        w_cnt_nxt        = r_cnt;
        w_i_done_nxt     = 1'b0;
        w_d_done_nxt     = 1'b0;
        w_i_rdata_nxt    = r_i_rdata;
        w_d_rdata_nxt    = r_d_rdata;
        w_armed_nxt      = r_armed;
        w_done           = 1'b0;
        w_fail           = 1'b0;
        w_rdata_fin      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_side_nxt       = w_grant_d;
                    w_last_grant_nxt = w_grant_d;
                    w_we_nxt         = w_grant_d ? d_we : 1'b0;
                    w_be_nxt         = w_grant_d ? d_be : '1;
                    w_addr_nxt       = w_grant_d ? d_addr : i_addr;
                    w_wdata_nxt      = w_grant_d ? d_wdata : '0;
                    w_mem_req_nxt    = 1'b1;
                    w_cnt_nxt        = '0;
                    w_armed_nxt      = 1'b1;
                end
            end
            S_WAIT_ACC: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (mem_ready) begin
                    w_mem_req_nxt = 1'b0;
                    if (r_we) begin
                        w_done = 1'b1;
                    end else if (mem_rvalid) begin
                        w_done      = 1'b1;
                        w_rdata_fin = mem_rdata;
                    end
                end else if (w_timeout) begin
                    w_mem_req_nxt = 1'b0;
                    w_done        = 1'b1;
                    w_fail        = 1'b1;
                end
            end
            S_WAIT_RESP: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (mem_rvalid) begin
                    w_done      = 1'b1;
                    w_rdata_fin = mem_rdata;
                end else if (w_timeout) begin
                    w_done = 1'b1;
                    w_fail = 1'b1;
                end
            end
            default: ;
        endcase
        if (w_done) begin
            if (r_side == SIDE_D) begin
                w_d_done_nxt  = 1'b1;
                w_d_rdata_nxt = w_rdata_fin;
            end else begin
                w_i_done_nxt  = 1'b1;
                w_i_rdata_nxt = w_rdata_fin;
            end
        end
        w_err_nxt = w_fail | w_proto;
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= SIDE_D;
            r_side       <= SIDE_I;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_req    <= 1'b0;
            r_cnt        <= '0;
            r_i_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_last_grant <= w_last_grant_nxt;
            r_side       <= w_side_nxt;
            r_we         <= w_we_nxt;
            r_be         <= w_be_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_cnt        <= w_cnt_nxt;
            r_i_done     <= w_i_done_nxt;
            r_d_done     <= w_d_done_nxt;
            r_i_rdata    <= w_i_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_err        <= w_err_nxt;
            r_err_sticky <= r_err_sticky | w_err_nxt;
            r_armed      <= w_armed_nxt;
        end
    end

    assign i_done     = r_i_done;
    assign i_rdata    = r_i_rdata;
    assign d_done     = r_d_done;
    assign d_rdata    = r_d_rdata;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_we;
    assign mem_be     = r_be;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign err        = r_err;
    assign err_sticky = r_err_sticky;

endmodule
